// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: fixed 35-cycle turnaround for every operation.
// Magnitude arithmetic in CALC, sign correction and word select in FIX.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      aluctrl_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          op_q;
  logic                a_neg_q, b_neg_q;
  logic [XLEN-1:0]     ma_q, mb_q;
  logic [2*XLEN-1:0]   prod_q;
  logic [XLEN-1:0]     result_q;

  // Accept-time decode
  logic            op_ok, a_sgn, b_sgn, a_neg_in, b_neg_in;
  logic [2:0]      op_in;
  logic [XLEN-1:0] ma_in, mb_in;

  always_comb begin
    op_ok = (aluctrl_i >= 5'd21) && (aluctrl_i <= 5'd28);
    op_in = 3'(aluctrl_i - 5'd21);
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_in)
      OpMulh, OpDiv, OpRem: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      OpMulhsu: a_sgn = 1'b1;
      default: ;
    endcase
    a_neg_in = a_sgn & a_i[XLEN-1];
    b_neg_in = b_sgn & b_i[XLEN-1];
    ma_in    = a_neg_in ? -a_i : a_i;
    mb_in    = b_neg_in ? -b_i : b_i;
  end

  // One iteration: multiply keeps {acc, multiplier}, divide keeps {remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, ma_q} : '0);
    mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mb_q};
    div_ge    = ~div_diff[XLEN];
    div_next  = {div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], prod_q[XLEN-2:0], div_ge};
  end

  // Sign correction and output word select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix, fix_word;

  always_comb begin
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod_q : prod_q;
    quo      = prod_q[XLEN-1:0];
    rem      = prod_q[2*XLEN-1:XLEN];
    // Divide by zero yields all-ones quotient regardless of signs
    quo_fix  = (mb_q == '0) ? '1 : ((a_neg_q ^ b_neg_q) ? -quo : quo);
    rem_fix  = a_neg_q ? -rem : rem;
    case (op_q)
      OpMul:                     fix_word = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_word = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_word = quo_fix;
      default:                   fix_word = rem_fix;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_i && op_ok) begin
            op_q    <= op_in;
            a_neg_q <= a_neg_in;
            b_neg_q <= b_neg_in;
            ma_q    <= ma_in;
            mb_q    <= mb_in;
            cnt_q   <= '0;
            prod_q  <= {{XLEN{1'b0}}, op_in[2] ? ma_in : mb_in};
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (kill_i) begin
            state_q <= StIdle;
          end else begin
            prod_q <= op_q[2] ? div_next : mul_next;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CntW'(XLEN - 1)) state_q <= StFix;
          end
        end
        StFix: begin
          if (kill_i) begin
            state_q <= StIdle;
          end else begin
            result_q <= fix_word;
            state_q  <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;

endmodule
